// File: rtl/yin_sched_pkg.sv
// Shared types and constants for the YIN frame scheduler and its pitch median filter.
package yin_sched_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP   = 2'd0,
    ST_WAIT_HOP = 2'd1,
    ST_START    = 2'd2,
    ST_BUSY     = 2'd3
  } sched_state_e;

  localparam int          Q_FRAC_BITS   = 16;
  localparam logic [31:0] F_MAX_DEFAULT = 32'd1000 << Q_FRAC_BITS;
  localparam int          FRAME_CNT_W   = 16;
  localparam int          OVR_CNT_W     = 8;

  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/pitch_median3.sv
// Median-of-3 filter on voiced pitches; built only when YIN_SCHED_MEDIAN3_EN is defined.
module pitch_median3
  import yin_sched_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             push_in,
  input  logic             clear_in,
  input  logic [WIDTH-1:0] din_in,
  output logic [WIDTH-1:0] dout_out
);

  // The incoming value plus the two stored ones form the 3-deep window.
  logic [WIDTH-1:0] hist0_q, hist0_d;
  logic [WIDTH-1:0] hist1_q, hist1_d;
  logic [1:0]       depth_q, depth_d;
  logic [WIDTH-1:0] lo, hi, med;

  always_comb begin
    lo  = (hist0_q < hist1_q) ? hist0_q : hist1_q;
    hi  = (hist0_q < hist1_q) ? hist1_q : hist0_q;
    med = (din_in < lo) ? lo : ((din_in > hi) ? hi : din_in);
    dout_out = (depth_q == 2'd2) ? med : din_in;
  end

  always_comb begin
    hist0_d = hist0_q;
    hist1_d = hist1_q;
    depth_d = depth_q;
    if (clear_in) begin
      hist0_d = '0;
      hist1_d = '0;
      depth_d = 2'd0;
    end else if (push_in) begin
      hist1_d = hist0_q;
      hist0_d = din_in;
      if (depth_q != 2'd2) depth_d = depth_q + 2'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hist0_q <= '0;
      hist1_q <= '0;
      depth_q <= 2'd0;
    end else begin
      hist0_q <= hist0_d;
      hist1_q <= hist1_d;
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/yin_frame_scheduler.sv
// Frames the sample stream for the YIN datapath and post-processes its pitch.
// Optional median-of-3 smoothing is enabled by defining YIN_SCHED_MEDIAN3_EN.
module yin_frame_scheduler
  import yin_sched_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter int               WINDOW_SIZE    = 500,
  parameter int               HOP_SIZE       = 250,
  parameter int               TIMEOUT_CYCLES = 200000,
  parameter int               HOLD_FRAMES    = 3,
  parameter logic [WIDTH-1:0] F_MAX_Q        = WIDTH'(F_MAX_DEFAULT)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   enable_in,
  input  logic                   sample_valid_in,
  output logic                   yin_sig_valid_out,
  output logic                   yin_start_out,
  output logic                   yin_abort_out,
  input  logic [WIDTH-1:0]       yin_f_in,
  input  logic                   yin_f_valid_in,
  output logic [WIDTH-1:0]       pitch_out,
  output logic                   pitch_valid_out,
  output logic                   voiced_out,
  output logic [FRAME_CNT_W-1:0] frame_count_out,
  output logic [OVR_CNT_W-1:0]   overrun_count_out,
  output logic                   timeout_out
);

  localparam int FILL_W = cnt_width(WINDOW_SIZE);
  localparam int HOP_W  = cnt_width(HOP_SIZE);
  localparam int TMO_W  = cnt_width(TIMEOUT_CYCLES);
  localparam int HOLD_W = cnt_width(HOLD_FRAMES);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WINDOW_SIZE);
  localparam logic [HOP_W-1:0]  HOP_LIM   = HOP_W'(HOP_SIZE);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(HOLD_FRAMES);

  sched_state_e           state_q, state_d;
  logic [FILL_W-1:0]      fill_cnt_q, fill_cnt_d;
  logic [HOP_W-1:0]       hop_cnt_q, hop_cnt_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0]       pitch_q, pitch_d;
  logic                   voiced_q, voiced_d;
  logic                   pitch_valid_q, pitch_valid_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [OVR_CNT_W-1:0]   ovr_cnt_q, ovr_cnt_d;
  logic                   timeout_q, timeout_d;

  logic             gate_open, fwd, result, tmo_hit, f_voiced, hold_ok;
  logic [WIDTH-1:0] pitch_sel;

  assign gate_open = (state_q == ST_WARMUP) || (state_q == ST_WAIT_HOP);
  assign fwd       = sample_valid_in && gate_open;
  assign result    = (state_q == ST_BUSY) && yin_f_valid_in;
  // A result arriving on the last allowed cycle takes priority over the abort.
  assign tmo_hit   = (state_q == ST_BUSY) && !yin_f_valid_in && (tmo_cnt_q == TMO_LAST);
  assign f_voiced  = (yin_f_in != '0) && (yin_f_in <= F_MAX_Q);
  assign hold_ok   = voiced_q && (hold_cnt_q < HOLD_LIM);

`ifdef YIN_SCHED_MEDIAN3_EN
  logic med_push, med_clear;
  assign med_push  = result && f_voiced;
  assign med_clear = tmo_hit || (result && !f_voiced && !hold_ok);

  pitch_median3 #(.WIDTH(WIDTH)) u_median (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push_in  (med_push),
    .clear_in (med_clear),
    .din_in   (yin_f_in),
    .dout_out (pitch_sel)
  );
`else
  assign pitch_sel = yin_f_in;
`endif

  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    hop_cnt_d     = hop_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    pitch_d       = pitch_q;
    voiced_d      = voiced_q;
    pitch_valid_d = result;
    frame_cnt_d   = frame_cnt_q;
    ovr_cnt_d     = ovr_cnt_q;
    timeout_d     = timeout_q;

    // Only ">= HOP_SIZE" matters, so the hop counter saturates there.
    if (state_q == ST_START) hop_cnt_d = '0;
    else if (sample_valid_in && hop_cnt_q != HOP_LIM) hop_cnt_d = hop_cnt_q + HOP_W'(1);

    if (tmo_hit) fill_cnt_d = '0;
    else if (fwd && fill_cnt_q != FILL_FULL) fill_cnt_d = fill_cnt_q + FILL_W'(1);

    if (state_q == ST_START) tmo_cnt_d = '0;
    else if (state_q == ST_BUSY) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);

    case (state_q)
      ST_WARMUP:   if (fill_cnt_d == FILL_FULL && enable_in) state_d = ST_START;
      ST_WAIT_HOP: if (hop_cnt_d >= HOP_LIM && enable_in) state_d = ST_START;
      ST_START:    state_d = ST_BUSY;
      ST_BUSY: begin
        if (result) begin
          frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
          if (hop_cnt_d >= HOP_LIM) begin
            if (ovr_cnt_q != '1) ovr_cnt_d = ovr_cnt_q + OVR_CNT_W'(1);
            state_d = enable_in ? ST_START : ST_WAIT_HOP;
          end else begin
            state_d = ST_WAIT_HOP;
          end
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_WARMUP;
        end
      end
      default: state_d = ST_WARMUP;
    endcase

    if (result) begin
      if (f_voiced) begin
        pitch_d    = pitch_sel;
        voiced_d   = 1'b1;
        hold_cnt_d = '0;
      end else if (hold_ok) begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end else begin
        pitch_d  = '0;
        voiced_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_WARMUP;
      fill_cnt_q    <= '0;
      hop_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      pitch_q       <= '0;
      voiced_q      <= 1'b0;
      pitch_valid_q <= 1'b0;
      frame_cnt_q   <= '0;
      ovr_cnt_q     <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      hop_cnt_q     <= hop_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      pitch_q       <= pitch_d;
      voiced_q      <= voiced_d;
      pitch_valid_q <= pitch_valid_d;
      frame_cnt_q   <= frame_cnt_d;
      ovr_cnt_q     <= ovr_cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  // Sample gate is forced low while reset is held so every output reads 0.
  assign yin_sig_valid_out = fwd && rst_n_in;
  assign yin_start_out     = (state_q == ST_START);
  assign yin_abort_out     = tmo_hit;
  assign pitch_out         = pitch_q;
  assign pitch_valid_out   = pitch_valid_q;
  assign voiced_out        = voiced_q;
  assign frame_count_out   = frame_cnt_q;
  assign overrun_count_out = ovr_cnt_q;
  assign timeout_out       = timeout_q;

endmodule

// File: tb/tb_yin_frame_scheduler.sv
// Directed, table-driven bench for yin_frame_scheduler (WINDOW=8, HOP=4, TIMEOUT=50, HOLD=2).
module tb_yin_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        sample_valid = 1'b0;
  logic [31:0] yin_f = '0;
  logic        yin_f_valid = 1'b0;
  logic        sig_valid, start, abort_p, pitch_valid, voiced, timeout;
  logic [31:0] pitch;
  logic [15:0] frames;
  logic [7:0]  overruns;

  int n_vec = 0;
  int n_err = 0;

  yin_frame_scheduler #(
    .WIDTH(32), .WINDOW_SIZE(8), .HOP_SIZE(4), .TIMEOUT_CYCLES(50), .HOLD_FRAMES(2),
    .F_MAX_Q(32'h03E8_0000)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(enable), .sample_valid_in(sample_valid),
    .yin_sig_valid_out(sig_valid), .yin_start_out(start), .yin_abort_out(abort_p),
    .yin_f_in(yin_f), .yin_f_valid_in(yin_f_valid), .pitch_out(pitch),
    .pitch_valid_out(pitch_valid), .voiced_out(voiced), .frame_count_out(frames),
    .overrun_count_out(overruns), .timeout_out(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required $finish before it");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] f;       // result returned on BUSY cycle 10
    int          s;       // strobes on BUSY cycles 1..s
    logic [31:0] p;       // expected pitch_out
    logic        v;       // expected voiced_out
    int          frames;  // expected frame_count_out
    int          ovr;     // expected overrun_count_out
    logic        st;      // START expected on cycle after the result
    int          hop;     // strobes needed in WAIT_HOP to reach START
  } vec_t;

`ifdef YIN_SCHED_MEDIAN3_EN
  localparam logic [31:0] V8_P = 32'h01B8_8000;
  localparam logic [31:0] M3_P = 32'h00D2_0000;
`else
  localparam logic [31:0] V8_P = 32'h0000_0001;
  localparam logic [31:0] M3_P = 32'h0064_0000;
`endif

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pitch"}, pitch, 0);
    check({tag, "_pitch_valid"}, {31'd0, pitch_valid}, 0);
    check({tag, "_voiced"}, {31'd0, voiced}, 0);
    check({tag, "_frames"}, {16'd0, frames}, 0);
    check({tag, "_overruns"}, {24'd0, overruns}, 0);
    check({tag, "_timeout"}, {31'd0, timeout}, 0);
    check({tag, "_start"}, {31'd0, start}, 0);
    check({tag, "_abort"}, {31'd0, abort_p}, 0);
    check({tag, "_sig_valid"}, {31'd0, sig_valid}, 0);
  endtask

  // Feeds one strobe per cycle until START appears; returns strobes used and forwarded.
  task automatic feed_until_start(output int n, output int fwd);
    n = 0;
    fwd = 0;
    while (n < 20) begin
      sample_valid = 1'b1;
      #1;
      if (sig_valid) fwd++;
      step();
      sample_valid = 1'b0;
      n++;
      if (start) break;
    end
  endtask

  // Entered on BUSY cycle 1; leaves on BUSY cycle 1 of the following frame.
  task automatic run_vec(input string tag, input int idx, input vec_t v);
    int leaked = 0;
    int n, fwd;
    for (int c = 1; c < 10; c++) begin
      sample_valid = (c <= v.s);
      #1;
      if (sig_valid) leaked++;
      step();
    end
    sample_valid = 1'b0;
    yin_f_valid = 1'b1;
    yin_f = v.f;
    step();
    yin_f_valid = 1'b0;
    yin_f = '0;
    $display("%s %0d: f=0x%08h strobes=%0d -> pitch=0x%08h voiced=%0d frames=%0d ovr=%0d",
             tag, idx, v.f, v.s, pitch, voiced, frames, overruns);
    check($sformatf("%s%0d_gate", tag, idx), leaked, 0);
    check($sformatf("%s%0d_pitch_valid", tag, idx), {31'd0, pitch_valid}, 1);
    check($sformatf("%s%0d_pitch", tag, idx), pitch, v.p);
    check($sformatf("%s%0d_voiced", tag, idx), {31'd0, voiced}, {31'd0, v.v});
    check($sformatf("%s%0d_frames", tag, idx), {16'd0, frames}, v.frames);
    check($sformatf("%s%0d_overruns", tag, idx), {24'd0, overruns}, v.ovr);
    check($sformatf("%s%0d_start", tag, idx), {31'd0, start}, {31'd0, v.st});
    if (v.st) begin
      step();
      check($sformatf("%s%0d_pv_pulse", tag, idx), {31'd0, pitch_valid}, 0);
    end else begin
      feed_until_start(n, fwd);
      check($sformatf("%s%0d_hop_strobes", tag, idx), n, v.hop);
      check($sformatf("%s%0d_hop_fwd", tag, idx), fwd, v.hop);
      step();
    end
  endtask

  vec_t tbl[9];
  vec_t mtbl[4];

  initial begin
    int starts, n, fwd, first_abort, aborts, pvs;

    tbl[0] = '{32'h00DC_0000, 2, 32'h00DC_0000, 1'b1, 1, 0, 1'b0, 2};
    tbl[1] = '{32'h00DC_0000, 5, 32'h00DC_0000, 1'b1, 2, 1, 1'b1, 0};
    tbl[2] = '{32'h0000_0000, 0, 32'h00DC_0000, 1'b1, 3, 1, 1'b0, 4};
    tbl[3] = '{32'h0400_0000, 1, 32'h00DC_0000, 1'b1, 4, 1, 1'b0, 3};
    tbl[4] = '{32'h0000_0000, 3, 32'h0000_0000, 1'b0, 5, 1, 1'b0, 1};
    tbl[5] = '{32'h03E8_0000, 0, 32'h03E8_0000, 1'b1, 6, 1, 1'b0, 4};
    tbl[6] = '{32'h03E8_0001, 0, 32'h03E8_0000, 1'b1, 7, 1, 1'b0, 4};
    tbl[7] = '{32'h01B8_8000, 4, 32'h01B8_8000, 1'b1, 8, 2, 1'b1, 0};
    tbl[8] = '{32'h0000_0001, 2, V8_P,         1'b1, 9, 2, 1'b0, 2};

    mtbl[0] = '{32'h00C8_0000, 0, 32'h00C8_0000, 1'b1, 1, 0, 1'b0, 4};
    mtbl[1] = '{32'h0384_0000, 0, 32'h0384_0000, 1'b1, 2, 0, 1'b0, 4};
    mtbl[2] = '{32'h00D2_0000, 0, 32'h00D2_0000, 1'b1, 3, 0, 1'b0, 4};
    mtbl[3] = '{32'h0064_0000, 0, M3_P,          1'b1, 4, 0, 1'b0, 4};

    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Warm-up: seven strobes three cycles apart must not start a frame.
    starts = 0;
    for (int i = 0; i < 7; i++) begin
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (start) starts++;
        if (k < 2) step();
      end
      step();
    end
    check("warm7_no_start", starts, 0);
    sample_valid = 1'b1;
    #1;
    check("warm_fwd", {31'd0, sig_valid}, 1);
    step();
    sample_valid = 1'b0;
    check("warm8_start", {31'd0, start}, 1);
    step();
    check("start_one_cycle", {31'd0, start}, 0);

    for (int i = 0; i < 9; i++) run_vec("vec", i, tbl[i]);

    // Timeout: no result; abort must land on BUSY cycle 50 only.
    first_abort = 0;
    aborts = 0;
    pvs = 0;
    for (int k = 1; k <= 60; k++) begin
      if (abort_p) begin
        if (first_abort == 0) first_abort = k;
        aborts++;
      end
      if (pitch_valid) pvs++;
      step();
    end
    $display("timeout: abort on BUSY cycle %0d, pulses=%0d, timeout=%0d", first_abort, aborts, timeout);
    check("tmo_abort_cycle", first_abort, 50);
    check("tmo_abort_pulses", aborts, 1);
    check("tmo_no_pitch_valid", pvs, 0);
    check("tmo_sticky", {31'd0, timeout}, 1);
    check("tmo_frames", {16'd0, frames}, 9);
    feed_until_start(n, fwd);
    check("tmo_refill_strobes", n, 8);
    step();

    // Result on the very cycle the timeout would fire wins over the abort.
    for (int k = 1; k < 50; k++) step();
    yin_f_valid = 1'b1;
    yin_f = 32'h00C8_0000;
    #1;
    check("edge_no_abort", {31'd0, abort_p}, 0);
    step();
    yin_f_valid = 1'b0;
    yin_f = '0;
    $display("edge: pitch=0x%08h voiced=%0d frames=%0d", pitch, voiced, frames);
    check("edge_pitch_valid", {31'd0, pitch_valid}, 1);
    check("edge_pitch", pitch, 32'h00C8_0000);
    check("edge_frames", {16'd0, frames}, 10);

    // enable_in low holds off START even with the hop complete.
    enable = 1'b0;
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      if (start) starts++;
    end
    check("disabled_no_start", starts, 0);
    enable = 1'b1;
    step();
    check("enable_start", {31'd0, start}, 1);
    step();
    step();
    step();

    // Asynchronous reset between edges while BUSY.
    check("pre_reset_timeout", {31'd0, timeout}, 1);
    rst_n = 1'b0;
    #1;
    $display("async reset: pitch=0x%08h frames=%0d timeout=%0d", pitch, frames, timeout);
    check_all_zero("async");
    step();
    rst_n = 1'b1;

    feed_until_start(n, fwd);
    check("rst_refill_strobes", n, 8);
    step();
    for (int i = 0; i < 4; i++) run_vec("med", i, mtbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
